// File: rtl/iq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : iq_sequencer
//  Description : Collects 8 upstream 96-bit coefficient columns into one 8x8
//                block. It issues the block to the inverse quantizer as one
//                contiguous 8-cycle burst, but only when the output FIFO has
//                room for all 8 results. It then queues the dequantized
//                columns, with a last flag, in a 16-entry FWFT FIFO.
//                Optional macro IQ_SEQ_STATS_EN adds a completed-block counter
//                (blocks_done_out).
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_sequencer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [95:0] s_column_in,
  input  logic        s_valid_in,
  output logic        s_ready_out,
  output logic        iq_rst_out,
  output logic [95:0] iq_column_out,
  output logic        iq_valid_out,
  input  logic [95:0] iq_column_in,
  input  logic        iq_valid_in,
  output logic [95:0] m_column_out,
  output logic        m_valid_out,
  output logic        m_last_out,
  input  logic        m_ready_in,
`ifdef IQ_SEQ_STATS_EN
  output logic [15:0] blocks_done_out,
`endif
  output logic        err_out
);

  localparam logic [4:0] FIFO_DEPTH  = 5'd16;
  localparam logic [5:0] ISSUE_LIMIT = 6'd8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  wr_idx, rd_idx;
  logic [95:0] buffer [8];
  logic [95:0] iq_col_q;
  logic        iq_vld_q;
  logic        iq_vld_d;       // iq_valid_out of the previous cycle
  logic [96:0] fifo_mem [16];
  logic [3:0]  fifo_wr_ptr, fifo_rd_ptr;
  logic [4:0]  fifo_count;
  logic [2:0]  push_cnt;
  logic        err_q;

  logic        fifo_full, pop, push_ok, push_drop, stray, room;

  // Handshake and FIFO control decode
  always_comb begin
    fifo_full = (fifo_count == FIFO_DEPTH);
    pop       = m_valid_out & m_ready_in;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    push_ok   = rst_in & iq_valid_in & (~fifo_full | pop);
    push_drop = iq_valid_in & fifo_full & ~pop;
    // Results arrive exactly one cycle after issue; anything else is a protocol error.
    stray     = iq_valid_in & ~iq_vld_d;
    // Only start a block when all 8 of its results are guaranteed a FIFO slot.
    room      = ({1'b0, fifo_count} + {5'd0, iq_vld_d}) <= ISSUE_LIMIT;
  end

  // Outputs are forced quiet while reset is held, even before the registers clear
  assign iq_rst_out    = ~rst_in;
  assign s_ready_out   = rst_in & (state == FILL);
  assign iq_valid_out  = rst_in & iq_vld_q;
  assign iq_column_out = rst_in ? iq_col_q : '0;
  assign m_valid_out   = rst_in & (fifo_count != 5'd0);
  assign m_column_out  = m_valid_out ? fifo_mem[fifo_rd_ptr][95:0] : '0;
  assign m_last_out    = m_valid_out & fifo_mem[fifo_rd_ptr][96];
  assign err_out       = rst_in & err_q;

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= FILL;
    else         state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (s_valid_in && wr_idx == 3'd7) state_nxt = WAIT;
      WAIT:    if (room)                         state_nxt = ISSUE;
      ISSUE:   if (rd_idx == 3'd7)               state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Block buffer storage (contents need no reset; indices gate their use)
  always_ff @(posedge clk_in) begin
    if (state == FILL && s_valid_in) buffer[wr_idx] <= s_column_in;
  end

  // Fill and issue column indices; both wrap back to 0 after column 7
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_idx <= 3'd0;
      rd_idx <= 3'd0;
    end else begin
      if (state == FILL && s_valid_in) wr_idx <= wr_idx + 3'd1;
      if (state == ISSUE)              rd_idx <= rd_idx + 3'd1;
    end
  end

  // Registered issue port towards the dequantizer
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      iq_col_q <= '0;
      iq_vld_q <= 1'b0;
      iq_vld_d <= 1'b0;
    end else begin
      iq_vld_q <= (state == ISSUE);
      if (state == ISSUE) iq_col_q <= buffer[rd_idx];
      iq_vld_d <= iq_vld_q;
    end
  end

  // FIFO storage; last flag marks every 8th returned column
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem[fifo_wr_ptr] <= {(push_cnt == 3'd7), iq_column_in};
  end

  // FIFO pointers, occupancy, push counter and sticky error
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      fifo_wr_ptr <= 4'd0;
      fifo_rd_ptr <= 4'd0;
      fifo_count  <= 5'd0;
      push_cnt    <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      if (push_ok) fifo_wr_ptr <= fifo_wr_ptr + 4'd1;
      if (pop)     fifo_rd_ptr <= fifo_rd_ptr + 4'd1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
      // Counts every returned column so block alignment survives a dropped push.
      if (iq_valid_in) push_cnt <= push_cnt + 3'd1;
      if (stray || push_drop) err_q <= 1'b1;
    end
  end

`ifdef IQ_SEQ_STATS_EN
  logic [15:0] blocks_q;

  // Completed-block counter, advanced when the last column leaves the FIFO
  always_ff @(posedge clk_in) begin
    if (!rst_in)                blocks_q <= 16'd0;
    else if (pop && m_last_out) blocks_q <= blocks_q + 16'd1;
  end

  assign blocks_done_out = blocks_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_sequencer
//  Description : Scoreboard bench for iq_sequencer with a 1-cycle dequantizer
//                model (element * (column+1), column counter reset by
//                iq_rst_out).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] s_column;
  logic        s_valid;
  logic        s_ready;
  logic        iq_rst;
  logic [95:0] iq_column;
  logic        iq_valid;
  logic [95:0] deq_column;
  logic        deq_valid;
  logic        inject;
  logic        iq_valid_ret;
  logic [95:0] m_column;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        err;
  logic [2:0]  deq_cnt;
`ifdef IQ_SEQ_STATS_EN
  logic [15:0] blocks_done;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [96:0] expq [$];
  int run_len = 0;

  assign iq_valid_ret = deq_valid | inject;

  iq_sequencer dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .s_column_in   (s_column),
    .s_valid_in    (s_valid),
    .s_ready_out   (s_ready),
    .iq_rst_out    (iq_rst),
    .iq_column_out (iq_column),
    .iq_valid_out  (iq_valid),
    .iq_column_in  (deq_column),
    .iq_valid_in   (iq_valid_ret),
    .m_column_out  (m_column),
    .m_valid_out   (m_valid),
    .m_last_out    (m_last),
    .m_ready_in    (m_ready),
`ifdef IQ_SEQ_STATS_EN
    .blocks_done_out (blocks_done),
`endif
    .err_out       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] deq(input logic [95:0] c, input logic [2:0] idx);
    logic [95:0] r;
    logic [11:0] q;
    logic [11:0] e;
    q = 12'(idx) + 12'd1;
    for (int i = 0; i < 8; i++) begin
      e = c[i*12 +: 12];
      r[i*12 +: 12] = 12'(e * q);
    end
    return r;
  endfunction

  function automatic logic [95:0] blk_col(input int b, input int c);
    logic [95:0] r;
    logic [11:0] e12;
    for (int e = 0; e < 8; e++) begin
      e12 = {4'(b), 4'(c), 4'(e)};
      if (e[0]) e12 = -e12;
      r[e*12 +: 12] = e12;
    end
    return r;
  endfunction

  // Dequantizer model: one-cycle latency, column counter reset by iq_rst
  always @(posedge clk) begin
    if (iq_rst) begin
      deq_cnt    <= 3'd0;
      deq_valid  <= 1'b0;
      deq_column <= '0;
    end else begin
      deq_valid <= iq_valid;
      if (iq_valid) begin
        deq_column <= deq(iq_column, deq_cnt);
        deq_cnt    <= deq_cnt + 3'd1;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on every accepted beat; issue bursts must be 8 long
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (expq.size() == 0) check("unexpected_beat", {m_last, m_column}, '0);
      else                  check("beat", {m_last, m_column}, expq.pop_front());
    end
    if (!rst_n) run_len = 0;
    else if (iq_valid) run_len++;
    else if (run_len != 0) begin
      check("issue_burst_len", run_len, 8);
      run_len = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_col(input logic [95:0] c);
    logic acc;
    int n;
    s_column = c;
    s_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 500);
    if (!acc) check("accept_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_block(input int b, input bit gap);
    for (int c = 0; c < 8; c++) begin
      send_col(blk_col(b, c));
      if (gap) cycles(1);
    end
  endtask

  task automatic expect_block(input int b);
    for (int c = 0; c < 8; c++) expq.push_back({(c == 7), deq(blk_col(b, c), 3'(c))});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 2000) begin cycles(1); n++; end
    check("drain", expq.size(), 0);
    cycles(3);
  endtask

  initial begin
    int n;
    logic quiet;
    rst_n = 1'b0; s_valid = 1'b0; s_column = '0; m_ready = 1'b1; inject = 1'b0;
    #1;
    cycles(3);
    @(negedge clk);
    check("reset_ctrl", {s_ready, iq_valid, m_valid, m_last, err, iq_rst}, 6'b000001);
    check("reset_iq_column", iq_column, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", s_ready, 1);
    @(posedge clk); #1;

    // Back-to-back block with latency measurement
    expect_block(0);
    send_block(0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!iq_valid && n < 50);
    check("iq_valid_seen", iq_valid, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 50);
    check("first_m_valid_latency", n, 2);
    @(posedge clk); #1;
    wait_drain();

    // Upstream valid toggling: nothing issues before the 8th accept
    expect_block(1);
    for (int c = 0; c < 7; c++) begin send_col(blk_col(1, c)); cycles(1); end
    cycles(4);
    @(negedge clk);
    check("no_issue_before_8th", {s_ready, iq_valid}, 2'b10);
    @(posedge clk); #1;
    send_col(blk_col(1, 7));
    wait_drain();

    // Downstream stalled: two blocks fill the FIFO, the third waits
    m_ready = 1'b0;
    for (int b = 2; b < 5; b++) begin expect_block(b); send_block(b, 1'b0); end
    cycles(20);
    @(negedge clk);
    check("held_in_wait", {s_ready, iq_valid, m_valid, err}, 4'b0010);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain();
`ifdef IQ_SEQ_STATS_EN
    @(negedge clk);
    check("blocks_done", blocks_done, 5);
    @(posedge clk); #1;
`endif

    // Reset during the 4th issue cycle discards the block
    m_ready = 1'b0;
    send_block(5, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!iq_valid && n < 50);
    check("iq_valid_seen_d", iq_valid, 1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_ctrl", {s_ready, iq_valid, m_valid, m_last, err, iq_rst}, 6'b000001);
    check("midreset_iq_column", iq_column, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b0;
    repeat (10) begin @(negedge clk); quiet = quiet | m_valid | iq_valid; end
    check("quiet_after_reset", {quiet, s_ready}, 2'b01);
    @(posedge clk); #1;
    m_ready = 1'b1;
    expect_block(6);
    send_block(6, 1'b0);
    wait_drain();

    // Spurious dequantizer valid in FILL sets the sticky error
    m_ready = 1'b0;
    @(negedge clk);
    check("err_clear_before", err, 0);
    @(posedge clk); #1;
    inject = 1'b1;
    cycles(1);
    inject = 1'b0;
    @(negedge clk);
    check("err_set", err, 1);
    @(posedge clk); #1;
    cycles(10);
    @(negedge clk);
    check("err_sticky", err, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("err_cleared_by_reset", {err, m_valid}, 2'b00);
    @(posedge clk); #1;
    m_ready = 1'b1;
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
